// File: rtl/sync_frame_pkg.sv
// Shared definitions for the sync-marker framing transmitter and its zero-run detector.
// Both sides take their run length from here so they can never disagree.
package sync_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_STUFF,
    ST_STOP
  } state_e;

  localparam int SYNC_LEN_DEF  = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int STUFF_RUN_DEF = SYNC_LEN_DEF - 1;

endpackage

// File: rtl/sync_frame_tx.sv
// Frame transmitter: SYNC_LEN zeros, start bit, MSB-first zero-stuffed payload, stop bit.
// line/busy/frame_done are registered from the current state, so they trail the state by one cycle.
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SYNC_LEN  = SYNC_LEN_DEF,
  parameter int STUFF_RUN = SYNC_LEN - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              line,
  output logic              busy,
  output logic              frame_done
);

  localparam int SCNT_W = $clog2(SYNC_LEN);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int ZRUN_W = $clog2(STUFF_RUN + 1);

  state_e              state_q, state_d;
  logic [SCNT_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ZRUN_W-1:0]   zrun_q, zrun_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                line_q, line_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic                bit_out;

  assign tx_ready   = (state_q == ST_IDLE) || (state_q == ST_STOP);
  assign accept     = tx_valid && tx_ready;
  assign bit_out    = shreg_q[DATA_W-1];
  assign line       = line_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    idx_d      = idx_q;
    zrun_d     = zrun_q;
    shreg_d    = shreg_q;
    line_d     = 1'b1;
    busy_d     = (state_q != ST_IDLE);
    done_d     = (state_q == ST_STOP);

    case (state_q)
      ST_IDLE, ST_STOP: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d    = ST_SYNC;
          shreg_d    = tx_data;
          idx_d      = '0;
          zrun_d     = '0;
          sync_cnt_d = '0;
        end
      end
      ST_SYNC: begin
        line_d = 1'b0;
        if (sync_cnt_q == SCNT_W'(SYNC_LEN - 1)) begin
          sync_cnt_d = '0;
          state_d    = ST_START;
        end else begin
          sync_cnt_d = sync_cnt_q + 1'b1;
        end
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        line_d  = bit_out;
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + 1'b1;
        zrun_d  = bit_out ? '0 : zrun_q + 1'b1;
        // The stop bit already breaks the run, so the last bit never gets a stuff bit.
        if (idx_q == IDX_W'(DATA_W - 1)) begin
          state_d = ST_STOP;
        end else if (zrun_d == ZRUN_W'(STUFF_RUN)) begin
          state_d = ST_STUFF;
        end
      end
      ST_STUFF: begin
        zrun_d  = '0;
        state_d = ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= '0;
      idx_q      <= '0;
      zrun_q     <= '0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      idx_q      <= idx_d;
      zrun_q     <= zrun_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx with a behavioural zero-run detector watching line.
module tb_sync_frame_tx;
  import sync_frame_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int SL = SYNC_LEN_DEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          line;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  sync_frame_tx #(
    .DATA_W   (DW),
    .SYNC_LEN (SL),
    .STUFF_RUN(STUFF_RUN_DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .line      (line),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int vecs = 0;
  int errs = 0;
  int zr = 0;
  int det_cnt = 0;
  int done_cnt = 0;

  // Loopback detector: one pulse each time a zero run reaches SL.
  always @(negedge clk) begin
    if (line === 1'b0) begin
      if (zr < SL) begin
        zr <= zr + 1;
        if (zr + 1 == SL) det_cnt <= det_cnt + 1;
      end
    end else begin
      zr <= 0;
    end
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int n, input int drop_at, output logic [63:0] bits,
                         output logic rdy5, output logic rdy17);
    bits  = '0;
    rdy5  = 1'bx;
    rdy17 = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == drop_at) tx_valid = 1'b0;
      if (i == 5) rdy5 = tx_ready;
      if (i == 17) rdy17 = tx_ready;
      bits = {bits[62:0], line};
    end
  endtask

  task automatic send_frame(input string tag, input logic [DW-1:0] word,
                            input logic [DW-1:0] mid_word, input int n,
                            input logic [63:0] exp_bits);
    int d0, f0;
    logic [63:0] bits;
    logic r5, r17;
    @(negedge clk);
    check({tag, "_ready_idle"}, 64'(tx_ready), 64'd1);
    tx_valid = 1'b1;
    tx_data  = word;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = mid_word;
    check({tag, "_latency_line"}, 64'(line), 64'd1);
    d0 = det_cnt;
    f0 = done_cnt;
    capture(n, 0, bits, r5, r17);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_ready_mid"}, 64'(r5), 64'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, line, busy}, 64'b10);
    @(posedge clk);
    #1;
    check({tag, "_det_pulses"}, 64'(det_cnt - d0), 64'd1);
    check({tag, "_done_pulses"}, 64'(done_cnt - f0), 64'd1);
  endtask

  initial begin
    int d0, f0;
    logic [63:0] bits;
    logic r5, r17;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_line", 64'(line), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_ready", 64'(tx_ready), 64'd1);

    // 00000000 1 10100101 1
    send_frame("a5", 8'hA5, 8'h5A, 18, 64'h34B);
    // 00000000 1 0000000 1(stuff) 1 1(stop); payload changed mid-frame to FF
    send_frame("x01", 8'h01, 8'hFF, 19, 64'h407);
    // 00000000 1 0000000 1(stuff) 0 1(stop)
    send_frame("x00", 8'h00, 8'h80, 19, 64'h405);

    // Back-to-back: FF then 00 with tx_valid held through the first frame.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_data = 8'h00;
    check("b2b_latency_line", 64'(line), 64'd1);
    d0 = det_cnt;
    f0 = done_cnt;
    capture(37, 18, bits, r5, r17);
    check("b2b_bits", bits, (64'h3FF << 19) | 64'h405);
    check("b2b_ready_stop", 64'(r17), 64'd1);
    @(negedge clk);
    check("b2b_idle_after", {62'd0, line, busy}, 64'b10);
    @(posedge clk);
    #1;
    check("b2b_det_pulses", 64'(det_cnt - d0), 64'd2);
    check("b2b_done_pulses", 64'(done_cnt - f0), 64'd2);

    // Reset during the 4th sync zero aborts the frame.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    d0 = det_cnt;
    f0 = done_cnt;
    repeat (4) @(negedge clk);
    check("abort_sync4_line", 64'(line), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_line", 64'(line), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(tx_ready), 64'd1);
    check("abort_done", 64'(frame_done), 64'd0);
    repeat (20) @(negedge clk);
    check("abort_quiet_line", {62'd0, line, busy}, 64'b10);
    @(posedge clk);
    #1;
    check("abort_det_pulses", 64'(det_cnt - d0), 64'd0);
    check("abort_done_pulses", 64'(done_cnt - f0), 64'd0);

    // Reset wins over tx_valid in the same cycle.
    @(negedge clk);
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clk);
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_prio_busy", 64'(busy), 64'd0);
    check("rst_prio_line", 64'(line), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
